// File: rtl/serdes_pkg.sv
// Shared constants, channel state encoding and CRC-8 step for the SerDes receive deframer.
// Defining SERDES_RX_CRC_EN turns on the trailing CRC-8 check and strip.
package serdes_pkg;

    localparam int unsigned KBit     = 8;
    localparam int unsigned ClsSync  = 0;
    localparam int unsigned ClsAsync = 1;
    localparam logic [7:0]  CrcPoly  = 8'h07;

`ifdef SERDES_RX_CRC_EN
    localparam bit CrcEn = 1'b1;
`else
    localparam bit CrcEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StFlush,
        StReady,
        StDrain
    } chan_state_e;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CrcPoly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/serdes_rx_chan.sv
// Per-class packet assembler: buffer, length counter, optional CRC register and channel FSM.
// The CRC register exists only when SERDES_RX_CRC_EN is defined.
module serdes_rx_chan
    import serdes_pkg::*;
#(
    parameter int unsigned  MAX_LEN = 32,
    localparam int unsigned AW      = $clog2(MAX_LEN)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [8:0]    sym_i,
    input  logic          grant_i,
    input  logic          done_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic [AW:0]   plen_o,
    output logic          ready_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam logic [AW:0] LenMax = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] LenOne = (AW+1)'(1);

    chan_state_e   state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    mem [MAX_LEN];
    logic          acc, first, is_k, crc_bad;
    logic [7:0]    data_in;
    logic [AW-1:0] wr_addr;

    assign is_k    = sym_i[KBit];
    assign data_in = sym_i[7:0];
    assign wr_addr = first ? '0 : len_q[AW-1:0];

`ifdef SERDES_RX_CRC_EN
    logic [7:0] crc_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= 8'h00;
        end else if (acc) begin
            crc_q <= crc8_step(first ? 8'h00 : crc_q, data_in);
        end
    end

    assign crc_bad = (crc_q != 8'h00);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc     = 1'b0;
        first   = 1'b0;
        err_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (we_i && !is_k) begin
                    acc     = 1'b1;
                    first   = 1'b1;
                    len_d   = LenOne;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (we_i && !is_k) begin
                    if (len_q == LenMax) begin
                        state_d = StFlush;
                    end else begin
                        acc   = 1'b1;
                        len_d = len_q + LenOne;
                    end
                end else if (we_i) begin
                    if (crc_bad) begin
                        err_o   = 1'b1;
                        state_d = StIdle;
                    end else if (CrcEn && len_q == LenOne) begin
                        // Only the CRC byte arrived: nothing to deliver.
                        state_d = StIdle;
                    end else begin
                        state_d = StReady;
                    end
                end
            end
            StFlush: begin
                if (we_i && is_k) begin
                    err_o   = 1'b1;
                    state_d = StIdle;
                end
            end
            StReady: begin
                if (grant_i) state_d = StDrain;
            end
            StDrain: begin
                if (done_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) mem[wr_addr] <= data_in;
    end

    assign rd_data_o = mem[rd_addr_i];
    assign plen_o    = CrcEn ? (len_q - LenOne) : len_q;
    assign ready_o   = (state_q == StReady);
    assign busy_o    = (state_q == StReady) || (state_q == StDrain);

endmodule

// File: rtl/serdes_rx_deframer.sv
// SerDes receive deframer top: two class assemblers, sync-first arbiter, registered byte output
// and saturating drop/error counters. SERDES_RX_CRC_EN enables the CRC-8 check in the channels.
module serdes_rx_deframer
    import serdes_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] sym_we_i,
    input  logic [8:0] sym_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       out_class_o,
    output logic       out_last_o,
    output logic [7:0] drop_cnt_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned AW = $clog2(MAX_LEN);

    logic [1:0]    we, rdy, busy, err, grant, done;
    logic [7:0]    rd_data [2];
    logic [AW:0]   plen [2];
    logic          draining_q, dcls_q;
    logic [AW-1:0] rd_ptr_q;
    logic          load, fin, drop;
    logic [7:0]    cur_data;
    logic [AW:0]   cur_plen;

    // Both strobes high means sync.
    assign we[ClsSync]  = sym_we_i[ClsSync];
    assign we[ClsAsync] = sym_we_i[ClsAsync] & ~sym_we_i[ClsSync];

    for (genvar c = 0; c < 2; c++) begin : g_chan
        serdes_rx_chan #(
            .MAX_LEN (MAX_LEN)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .we_i      (we[c]),
            .sym_i     (sym_i),
            .grant_i   (grant[c]),
            .done_i    (done[c]),
            .rd_addr_i (rd_ptr_q),
            .rd_data_o (rd_data[c]),
            .plen_o    (plen[c]),
            .ready_o   (rdy[c]),
            .busy_o    (busy[c]),
            .err_o     (err[c])
        );
    end

    assign grant[ClsSync]  = ~draining_q & rdy[ClsSync];
    assign grant[ClsAsync] = ~draining_q & ~rdy[ClsSync] & rdy[ClsAsync];

    assign cur_data = rd_data[dcls_q];
    assign cur_plen = plen[dcls_q];

    // Refill the output register when it is empty or its non-final byte is taken.
    assign load = draining_q & (~out_valid_o | (out_ready_i & ~out_last_o));
    assign fin  = draining_q & out_valid_o & out_ready_i & out_last_o;

    assign done[ClsSync]  = fin & ~dcls_q;
    assign done[ClsAsync] = fin & dcls_q;
    assign drop           = |(we & busy);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            draining_q  <= 1'b0;
            dcls_q      <= 1'b0;
            rd_ptr_q    <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= 8'h00;
            out_class_o <= 1'b0;
            out_last_o  <= 1'b0;
            drop_cnt_o  <= 8'h00;
            err_cnt_o   <= 8'h00;
        end else begin
            if (|grant) begin
                draining_q <= 1'b1;
                dcls_q     <= grant[ClsAsync];
                rd_ptr_q   <= '0;
            end else if (fin) begin
                draining_q <= 1'b0;
            end
            if (load) begin
                out_valid_o <= 1'b1;
                out_data_o  <= cur_data;
                out_class_o <= dcls_q;
                out_last_o  <= ({1'b0, rd_ptr_q} == (cur_plen - (AW+1)'(1)));
                rd_ptr_q    <= rd_ptr_q + AW'(1);
            end else if (fin) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
            end
            if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            if ((|err) && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_serdes_rx_deframer.sv
// Directed self-checking bench for serdes_rx_deframer; follows SERDES_RX_CRC_EN if defined.
`timescale 1ns/1ps
module tb_serdes_rx_deframer;

`ifdef SERDES_RX_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif
    localparam int unsigned MAX_LEN = 32;
    localparam logic [8:0]  K_SYM   = 9'h1BC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sym_we;
    logic [8:0] sym;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_class;
    logic       out_last;
    logic [7:0] drop_cnt;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int err_exp = 0;
    int drop_exp = 0;

    logic [9:0] cap[$];
    logic [9:0] exp_q[$];
    logic [7:0] pkt[$];
    logic       gap_bad = 1'b0;
    logic       prev_last = 1'b0;

    serdes_rx_deframer #(
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .sym_we_i    (sym_we),
        .sym_i       (sym),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_class_o (out_class),
        .out_last_o  (out_last),
        .drop_cnt_o  (drop_cnt),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    // Record accepted bytes; valid must drop for a cycle after every final byte.
    always @(negedge clk) begin
        if (prev_last && out_valid) gap_bad = 1'b1;
        prev_last = out_valid && out_ready && out_last;
        if (out_valid && out_ready) cap.push_back({out_class, out_last, out_data});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Bit-serial reference CRC-8, poly 0x07.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic put(input logic [1:0] we, input logic [8:0] s);
        sym_we = we;
        sym    = s;
        @(posedge clk);
        #1;
        sym_we = 2'b00;
        sym    = K_SYM;
    endtask

    // Sends pkt on one class, with CRC trailer (XOR flip) when CRC is built, then K.
    task automatic send_pkt(input logic cls, input bit expect_out, input logic [7:0] flip);
        logic [7:0] c;
        logic [1:0] we;
        c  = 8'h00;
        we = cls ? 2'b10 : 2'b01;
        for (int i = 0; i < pkt.size(); i++) begin
            put(we, {1'b0, pkt[i]});
            c = crc8_byte(c, pkt[i]);
            if (expect_out) exp_q.push_back({cls, (i == pkt.size() - 1), pkt[i]});
        end
        if (CRC) put(we, {1'b0, c ^ flip});
        put(we, K_SYM);
    endtask

    task automatic check_out(input string tag);
        int n;
        n = 0;
        while (cap.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (8) @(negedge clk);
        #1;
        chk({tag, "_count"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {22'd0, cap[i]}, {22'd0, exp_q[i]});
        end
        cap.delete();
        exp_q.delete();
    endtask

    task automatic check_cnt(input string tag);
        chk({tag, "_err"}, {24'd0, err_cnt}, err_exp);
        chk({tag, "_drop"}, {24'd0, drop_cnt}, drop_exp);
    endtask

    initial begin
        int n;
        logic [7:0] cs;
        logic [7:0] ca;
        rst_n     = 1'b0;
        sym_we    = 2'b00;
        sym       = K_SYM;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_class", {31'd0, out_class}, 0);
        chk("rst_last", {31'd0, out_last}, 0);
        check_cnt("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sync packet 01 02 03 (CRC trailer 0x48 when built).
        pkt = '{8'h01, 8'h02, 8'h03};
        send_pkt(1'b0, 1'b1, 8'h00);
        check_out("good");
        check_cnt("good");

        // Corrupted CRC is discarded; without CRC the extra byte is ordinary payload.
`ifdef SERDES_RX_CRC_EN
        pkt = '{8'h01, 8'h02, 8'h03};
        send_pkt(1'b0, 1'b0, 8'h01);
        err_exp++;
`else
        pkt = '{8'h01, 8'h02, 8'h03, 8'h49};
        send_pkt(1'b0, 1'b1, 8'h00);
`endif
        check_out("badcrc");
        check_cnt("badcrc");

        // Interleaved async(4) / sync(2); sync terminates first.
        cs = crc8_byte(crc8_byte(8'h00, 8'h51), 8'h52);
        ca = crc8_byte(crc8_byte(crc8_byte(crc8_byte(8'h00, 8'hA0), 8'hA1), 8'hA2), 8'hA3);
        put(2'b10, 9'h0A0);
        put(2'b01, 9'h051);
        put(2'b10, 9'h0A1);
        put(2'b01, 9'h052);
        put(2'b10, 9'h0A2);
        put(2'b10, 9'h0A3);
        if (CRC) begin
            put(2'b01, {1'b0, cs});
            put(2'b10, {1'b0, ca});
        end
        put(2'b01, K_SYM);
        put(2'b10, K_SYM);
        exp_q = '{{2'b00, 8'h51}, {2'b01, 8'h52},
                  {2'b10, 8'hA0}, {2'b10, 8'hA1}, {2'b10, 8'hA2}, {2'b11, 8'hA3}};
        check_out("prio");
        chk("prio_gap", {31'd0, gap_bad}, 0);

        // Backpressure for 5 cycles in the middle of a packet.
        pkt = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        send_pkt(1'b0, 1'b1, 8'h00);
        n = 0;
        while (cap.size() < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 1);
            chk($sformatf("stall_data%0d", i), {24'd0, out_data}, 32'h30);
            chk($sformatf("stall_last%0d", i), {31'd0, out_last}, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check_out("stall");

        // Overlength packet, then a good one.
        for (int i = 0; i < MAX_LEN + 1; i++) put(2'b01, {1'b0, 8'(i)});
        put(2'b01, K_SYM);
        err_exp++;
        pkt = '{8'hC1, 8'hC2};
        send_pkt(1'b0, 1'b1, 8'h00);
        check_out("ovl");
        check_cnt("ovl");

        // Drops while async channel holds a packet under backpressure.
        out_ready = 1'b0;
        pkt = '{8'hE1, 8'hE2, 8'hE3};
        send_pkt(1'b1, 1'b1, 8'h00);
        put(2'b10, 9'h0F1);
        put(2'b10, 9'h0F2);
        put(2'b10, 9'h0F3);
        drop_exp += 3;
        check_cnt("drop");
        chk("drop_valid", {31'd0, out_valid}, 1);
        chk("drop_head", {23'd0, out_class, out_data}, {23'd0, 1'b1, 8'hE1});
        out_ready = 1'b1;
        check_out("drop");
        chk("final_gap", {31'd0, gap_bad}, 0);

        // Reset mid-packet discards the partial packet and clears counters.
        put(2'b01, 9'h077);
        put(2'b01, 9'h078);
        rst_n = 1'b0;
        @(negedge clk);
        err_exp  = 0;
        drop_exp = 0;
        check_cnt("midrst");
        chk("midrst_valid", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pkt = '{8'h5A, 8'hA5};
        send_pkt(1'b0, 1'b1, 8'h00);
        check_out("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
